// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM encoding, line geometry and address field-width helpers.
package data_cache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    localparam int ADDR_W     = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_REQ  = 3'd4
    } dc_state_t;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

    // Replace the byte lanes selected by be, keep the others
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                result[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid + tag storage for the data cache: flop valid bits with a one-cycle
// synchronous clear, one combinational read port and one write port.
module dcache_tag_array
    import data_cache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_mem_r [LINES];

    // Valid bits: whole-array clear has priority over a line fill
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_r <= {LINES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_mem_r[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache (16 B lines).
// Optional read hit/miss counters are enabled with macro DCACHE_STATS_EN.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dcache_addr,
    input  logic         dcache_re,
    input  logic [3:0]   dcache_we,
    input  logic [31:0]  dcache_din,
    output logic [31:0]  dcache_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rnw,
    output logic [27:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    output logic [15:0]  mem_req_mask,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(LINES);

    dc_state_t        state_r, state_next_s;
    logic             req_valid_r;
    logic [31:2]      req_addr_r;
    logic [3:0]       req_we_r;
    logic [31:0]      req_din_r;
    logic [31:0]      dout_r;
    logic [127:0]     data_mem_r [LINES];

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [1:0]       word_s;
    logic [127:0]     line_s;
    logic [31:0]      word_data_s;
    logic             rd_valid_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic             hit_s, c1_s, is_wr_s;
    logic             rd_hit_s, rd_miss_s, wr_hit_s, load_s, refill_s;
    logic             stall_s, req_valid_s, req_rnw_s, accept_s;
    logic             unused_addr_lsb_s;

    // Byte-offset bits are aligned away by the CPU
    assign unused_addr_lsb_s = ^dcache_addr[1:0];

    assign idx_s       = req_addr_r[OFFSET_W +: IDX_W];
    assign tag_s       = req_addr_r[31 -: TAG_W];
    assign word_s      = req_addr_r[3:2];
    assign line_s      = data_mem_r[idx_s];
    assign word_data_s = line_s[{word_s, 5'b00000} +: 32];

    dcache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .clr      (rst),
        .rd_idx   (idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .wr_en    (refill_s),
        .wr_idx   (idx_s),
        .wr_tag   (tag_s)
    );

    assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);
    assign c1_s      = (state_r == IDLE) && req_valid_r;
    assign is_wr_s   = (req_we_r != 4'b0000);
    assign rd_hit_s  = c1_s && !is_wr_s && hit_s;
    assign rd_miss_s = c1_s && !is_wr_s && !hit_s;
    assign wr_hit_s  = c1_s && is_wr_s && hit_s;
    assign load_s    = rd_hit_s || (state_r == RD_DONE);
    assign refill_s  = (state_r == RD_WAIT) && mem_resp_valid;
    assign accept_s  = !stall_s && (dcache_re || (dcache_we != 4'b0000));

    // Next-state and handshake/stall decode
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        req_valid_s  = 1'b0;
        req_rnw_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (c1_s) begin
                    if (is_wr_s) begin
                        state_next_s = WR_REQ;
                        stall_s      = 1'b1;
                    end else if (!hit_s) begin
                        state_next_s = RD_REQ;
                        stall_s      = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_REQ: begin
                stall_s     = 1'b1;
                req_valid_s = 1'b1;
                req_rnw_s   = 1'b1;
                if (mem_req_ready) begin
                    state_next_s = RD_WAIT;
                end else begin
                    state_next_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                stall_s = 1'b1;
                if (mem_resp_valid) begin
                    state_next_s = RD_DONE;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            RD_DONE: begin
                state_next_s = IDLE;
            end
            WR_REQ: begin
                stall_s     = 1'b1;
                req_valid_s = 1'b1;
                if (mem_req_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WR_REQ;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture; fields stay frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_r <= 1'b0;
            req_addr_r  <= 30'd0;
            req_we_r    <= 4'b0000;
            req_din_r   <= 32'd0;
        end else begin
            req_valid_r <= accept_s;
            if (accept_s) begin
                req_addr_r <= dcache_addr[31:2];
                req_we_r   <= dcache_we;
                req_din_r  <= dcache_din;
            end
        end
    end

    // Load data holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= 32'd0;
        end else if (load_s) begin
            dout_r <= word_data_s;
        end
    end

    // Line data: refill writes whole line, write hit merges bytes of one word
    always_ff @(posedge clk) begin
        if (refill_s) begin
            data_mem_r[idx_s] <= mem_resp_data;
        end else if (wr_hit_s) begin
            data_mem_r[idx_s][{word_s, 5'b00000} +: 32] <= merge_bytes(word_data_s, req_din_r, req_we_r);
        end
    end

    assign dcache_dout   = load_s ? word_data_s : dout_r;
    assign stall         = stall_s;
    assign mem_req_valid = req_valid_s;
    assign mem_req_rnw   = req_rnw_s;
    assign mem_req_addr  = req_addr_r[31:4];
    assign mem_req_data  = {4{req_din_r}};
    assign mem_req_mask  = {12'h000, req_we_r} << {word_s, 2'b00};

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_r, miss_count_r;

    // Saturating read hit/miss counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (rd_hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (rd_miss_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`else
    logic unused_miss_s;
    assign unused_miss_s = rd_miss_s;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache: refill, hit, store hit/miss,
// stalled handshake and reset during refill.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rnw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_cache #(.LINES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        dcache_addr    = 32'd0;
        dcache_re      = 1'b0;
        dcache_we      = 4'b0000;
        dcache_din     = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'd0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("reset_dout", dcache_dout, 32'd0);

        // Cold read miss with ready held low for 5 cycles
        dcache_addr = 32'h1000_0040;
        dcache_re   = 1'b1;
        tick;
        chk("miss_c1_stall", {31'd0, stall}, 32'd1);
        chk("miss_c1_no_req", {31'd0, mem_req_valid}, 32'd0);
        dcache_re = 1'b0;
        tick;
        chk("rdreq_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("rdreq_rnw", {31'd0, mem_req_rnw}, 32'd1);
        chk("rdreq_addr", {4'd0, mem_req_addr}, 32'h0100_0004);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rdreq_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("rdreq_hold_addr", {4'd0, mem_req_addr}, 32'h0100_0004);
            chk("rdreq_hold_stall", {31'd0, stall}, 32'd1);
        end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        chk("rdwait_valid_low", {31'd0, mem_req_valid}, 32'd0);
        chk("rdwait_stall", {31'd0, stall}, 32'd1);
        tick;
        chk("rdwait_no_dup", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        tick;
        mem_resp_valid = 1'b0;
        chk("rddone_stall", {31'd0, stall}, 32'd0);
        chk("rddone_dout", dcache_dout, 32'hAAAA_AAAA);

        // Hit on the refilled line, accepted straight out of RD_DONE
        dcache_addr = 32'h1000_0044;
        dcache_re   = 1'b1;
        tick;
        chk("hit_dout", dcache_dout, 32'hBBBB_BBBB);
        chk("hit_stall", {31'd0, stall}, 32'd0);
        chk("hit_no_req", {31'd0, mem_req_valid}, 32'd0);
        dcache_re = 1'b0;
        tick;
        chk("idle_dout_hold", dcache_dout, 32'hBBBB_BBBB);

        // Store hit, two low bytes at word 2
        dcache_addr = 32'h1000_0048;
        dcache_we   = 4'b0011;
        dcache_din  = 32'h1234_5678;
        tick;
        chk("wr_c1_stall", {31'd0, stall}, 32'd1);
        dcache_we = 4'b0000;
        tick;
        chk("wrreq_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("wrreq_rnw", {31'd0, mem_req_rnw}, 32'd0);
        chk("wrreq_mask", {16'd0, mem_req_mask}, 32'h0000_0300);
        chk("wrreq_data_lo", mem_req_data[31:0], 32'h1234_5678);
        chk("wrreq_data_hi", mem_req_data[127:96], 32'h1234_5678);
        chk("wrreq_addr", {4'd0, mem_req_addr}, 32'h0100_0004);
        chk("wrreq_dout_hold", dcache_dout, 32'hBBBB_BBBB);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        chk("wr_done_stall", {31'd0, stall}, 32'd0);
        chk("wr_done_valid", {31'd0, mem_req_valid}, 32'd0);
        dcache_addr = 32'h1000_0048;
        dcache_re   = 1'b1;
        tick;
        dcache_re = 1'b0;
        chk("merged_read", dcache_dout, 32'hCCCC_5678);
        chk("merged_stall", {31'd0, stall}, 32'd0);
`ifdef DCACHE_STATS_EN
        tick;
        chk("stats_miss", miss_count, 32'd1);
        chk("stats_hit", hit_count, 32'd2);
`endif

        // Store miss to a conflicting tag must not touch the cached line
        dcache_addr = 32'h2000_0040;
        dcache_we   = 4'b1111;
        dcache_din  = 32'hFFFF_FFFF;
        tick;
        dcache_we = 4'b0000;
        chk("wrmiss_c1_stall", {31'd0, stall}, 32'd1);
        tick;
        chk("wrmiss_mask", {16'd0, mem_req_mask}, 32'h0000_000F);
        chk("wrmiss_addr", {4'd0, mem_req_addr}, 32'h0200_0004);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        dcache_addr = 32'h1000_0040;
        dcache_re   = 1'b1;
        tick;
        chk("after_wrmiss_hit", dcache_dout, 32'hAAAA_AAAA);
        chk("after_wrmiss_stall", {31'd0, stall}, 32'd0);

        // Read the no-allocate address: miss, then reset during RD_WAIT
        dcache_addr = 32'h2000_0040;
        tick;
        dcache_re = 1'b0;
        chk("noalloc_miss_stall", {31'd0, stall}, 32'd1);
        tick;
        chk("noalloc_req_addr", {4'd0, mem_req_addr}, 32'h0200_0004);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mid_dout", dcache_dout, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        tick;
        mem_resp_valid = 1'b0;
        chk("stale_resp_stall", {31'd0, stall}, 32'd0);
        chk("stale_resp_dout", dcache_dout, 32'd0);
        dcache_addr = 32'h2000_0040;
        dcache_re   = 1'b1;
        tick;
        dcache_re = 1'b0;
        chk("post_rst_miss", {31'd0, stall}, 32'd1);
        tick;
        chk("post_rst_req", {31'd0, mem_req_valid}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        dcache_addr = 32'h1000_0040;
        dcache_re   = 1'b1;
        tick;
        dcache_re = 1'b0;
        chk("cleared_line_miss", {31'd0, stall}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: LINES, 64, number of direct-mapped lines (power of two, 16 B/line).
REQ-002 Ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 dcache_addr  in  32  CPU byte address; dcache_re  in  1  read request; dcache_we  in  4  byte write enables; dcache_din  in  32  store data.
REQ-005 dcache_dout  out  32  load data; stall  out  1  CPU hold request.
REQ-006 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_rnw  out  1 (1=line read); mem_req_addr  out  28  line address; mem_req_data  out  128; mem_req_mask  out  16  byte mask.
REQ-007 mem_resp_valid  in  1; mem_resp_data  in  128  refill line.

Function
REQ-008 A request is accepted on a rising edge where stall=0 and (dcache_re=1 or dcache_we!=0); it is registered, and tag/valid lookup occurs the following cycle (C1).
REQ-009 dcache_we!=0 takes precedence over dcache_re when both are set.
REQ-010 Read hit: dcache_dout = selected word in C1, stall=0 in C1 (one-cycle latency, matching block-RAM timing).
REQ-011 Read miss: stall=1 from C1; FSM IDLE->RD_REQ; mem_req_valid=1, rnw=1, addr=dcache_addr[31:4] held until mem_req_ready; ->RD_WAIT; on mem_resp_valid line, tag and valid are written; ->RD_DONE; dcache_dout = requested word and stall=0 in RD_DONE; ->IDLE.
REQ-012 Writes are write-through, no-write-allocate: C1 -> WR_REQ with stall=1; mem_req_rnw=0, data = dcache_din replicated to 4 lanes, mask = dcache_we shifted to word offset addr[3:2]; stall drops the cycle after the mem_req_valid&mem_req_ready handshake.
REQ-013 Write hit additionally updates enabled bytes of the cached word in the same cycle as the lookup; a write miss leaves cache contents unchanged.
REQ-014 mem_req_* outputs are stable while mem_req_valid=1 and mem_req_ready=0; mem_req_valid deasserts the cycle after the handshake.
REQ-015 mem_resp_valid outside RD_WAIT is ignored.
REQ-016 Index = addr[4+log2(LINES)-1:4], tag = addr[31:4+log2(LINES)], word = addr[3:2]; addr[1:0] ignored (alignment done by CPU).
REQ-017 No request is accepted while stall=1; CPU inputs are don't-care during stall.
REQ-018 dcache_dout holds its last value in cycles without a completed read.

Reset
REQ-019 On rst=1 at a clock edge: FSM=IDLE, all valid bits cleared, stall=0, mem_req_valid=0, dcache_dout=0, pending request discarded.
REQ-020 rst mid-refill: FSM returns to IDLE; a later stale mem_resp_valid is ignored per REQ-015; no line becomes valid.
REQ-021 Clearing valid bits takes one cycle (flop array, not RAM); tag/data storage is not reset.

Configuration
REQ-022 Macro DCACHE_STATS_EN: when defined, adds outputs hit_count 32 and miss_count 32, counting read hits and read misses, saturating at 32'hFFFFFFFF, reset to 0; when undefined, the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-023 Shared package holds FSM state encoding (IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ), line-size constant (16 B) and the address field-width functions.
REQ-024 One sub-module, dcache_tag_array: valid+tag storage with synchronous clear, single read port and single write port.

Verification
REQ-025 Cold read 0x10000040 -> stall=1 from C1, mem_req addr=0x1000004 rnw=1; responding with line 0x..DDDD_CCCC_BBBB_AAAA returns dcache_dout=0xAAAAAAAA, stall low in RD_DONE.
REQ-026 Repeat read 0x10000044 after REQ-025 -> hit, dcache_dout=0xBBBBBBBB in C1, no mem_req.
REQ-027 Store we=4'b0011 din=0x12345678 at 0x10000048 (hit) -> mem_req rnw=0 mask=16'h0300; subsequent read returns 0xCCCC5678.
REQ-028 mem_req_ready held low 5 cycles during a refill -> request fields stable, stall=1 throughout, no duplicate request.
REQ-029 rst asserted in RD_WAIT, then mem_resp_valid pulsed -> IDLE, read of same address misses again.
REQ-030 With DCACHE_STATS_EN: sequence miss, hit, hit -> miss_count=1, hit_count=2.
